// File: rtl/sdc_single_blk_wr_mod_if.sv
// SD single-block write: host/FIFO and D0 line bundle.
// master = host side, slave = write engine.
interface sdc_single_blk_wr_mod_if;
  logic [15:0] command;
  logic        wr_strt;
  logic [63:0] dat_wrd;
  logic        d0_in;
  logic        rd_wrd_strb;
  logic        d0_out;
  logic        d0_oe;
  logic        busy;
  logic        tfc;
  logic        wr_err;
  logic [2:0]  crc_stat;

  modport master (
    output command,
    output wr_strt,
    output dat_wrd,
    output d0_in,
    input  rd_wrd_strb,
    input  d0_out,
    input  d0_oe,
    input  busy,
    input  tfc,
    input  wr_err,
    input  crc_stat
  );

  modport slave (
    input  command,
    input  wr_strt,
    input  dat_wrd,
    input  d0_in,
    output rd_wrd_strb,
    output d0_out,
    output d0_oe,
    output busy,
    output tfc,
    output wr_err,
    output crc_stat
  );
endinterface

// File: rtl/sdc_single_blk_wr_mod.sv
// SD single-block (512 B) write engine on D0:
// start bit, 4096 data bits, CRC16, end bit, CRC status, busy.
module sdc_single_blk_wr_mod (
  input  logic sdc_clk,
  input  logic reset,
  sdc_single_blk_wr_mod_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    START     = 4'd2,
    DATA      = 4'd3,
    CRC       = 4'd4,
    END       = 4'd5,
    WAIT_STAT = 4'd6,
    RD_STAT   = 4'd7,
    WAIT_BUSY = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [62:0] sh_q, sh_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_upd;
  logic [5:0]  bit_q, bit_d;
  logic [6:0]  wrd_q, wrd_d;
  logic [4:0]  cbit_q, cbit_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  stat_q, stat_d;
  logic        err_q, err_d;
  logic        dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        strb_q, strb_d;
  logic        busy_q, busy_d;
  logic        tfc_q, tfc_d;
  logic        cmd_ok;
  logic        cmd_unused;

  assign cmd_ok = (bus.command[13:8] == 6'h18) ||
                  (bus.command[13:8] == 6'h19);
  assign cmd_unused = &{1'b0, bus.command[15:14],
                        bus.command[7:0]};

  // serial CRC16-CCITT step on the bit currently on D0
  assign crc_upd = {crc_q[14:0], 1'b0} ^
                   ({16{crc_q[15] ^ dout_q}} & 16'h1021);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    crc_d   = crc_q;
    bit_d   = bit_q;
    wrd_d   = wrd_q;
    cbit_d  = cbit_q;
    tmo_d   = tmo_q;
    stat_d  = stat_q;
    err_d   = err_q;
    dout_d  = 1'b1;
    strb_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_strt && cmd_ok) begin
          state_d = FETCH;
          strb_d  = 1'b1;
          stat_d  = 3'b000;
          err_d   = 1'b0;
          crc_d   = 16'h0000;
          bit_d   = 6'd0;
          wrd_d   = 7'd0;
          cbit_d  = 5'd0;
          tmo_d   = 16'd0;
        end
      end
      FETCH: begin
        if (cbit_q[0]) begin
          state_d = START;
          dout_d  = 1'b0;
          cbit_d  = 5'd0;
        end else begin
          cbit_d = 5'd1;
        end
      end
      START: begin
        state_d = DATA;
        sh_d    = bus.dat_wrd[62:0];
        dout_d  = bus.dat_wrd[63];
        bit_d   = 6'd63;
        wrd_d   = 7'd0;
      end
      DATA: begin
        crc_d = crc_upd;
        if (bit_q == 6'd0) begin
          if (wrd_q == 7'd63) begin
            state_d = CRC;
            dout_d  = crc_upd[15];
            cbit_d  = 5'd0;
          end else begin
            sh_d   = bus.dat_wrd[62:0];
            dout_d = bus.dat_wrd[63];
            bit_d  = 6'd63;
            wrd_d  = wrd_q + 7'd1;
          end
        end else begin
          sh_d   = {sh_q[61:0], 1'b0};
          dout_d = sh_q[62];
          bit_d  = bit_q - 6'd1;
          strb_d = (bit_q == 6'd3) && (wrd_q != 7'd63);
        end
      end
      CRC: begin
        if (cbit_q == 5'd15) begin
          state_d = END;
          dout_d  = 1'b1;
        end else begin
          crc_d  = {crc_q[14:0], 1'b0};
          dout_d = crc_q[14];
          cbit_d = cbit_q + 5'd1;
        end
      end
      END: begin
        state_d = WAIT_STAT;
        tmo_d   = 16'd0;
      end
      WAIT_STAT: begin
        if (!bus.d0_in) begin
          state_d = RD_STAT;
          cbit_d  = 5'd0;
        end else if (tmo_q == 16'd15) begin
          state_d = DONE;
          stat_d  = 3'b111;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RD_STAT: begin
        if (cbit_q == 5'd3) begin
          state_d = WAIT_BUSY;
          err_d   = (stat_q != 3'b010);
          tmo_d   = 16'd0;
        end else begin
          stat_d = {stat_q[1:0], bus.d0_in};
          cbit_d = cbit_q + 5'd1;
        end
      end
      WAIT_BUSY: begin
        if (bus.d0_in) begin
          state_d = DONE;
        end else if (tmo_q == 16'hFFFE) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sh_d    = '0;
        crc_d   = 16'h0000;
        bit_d   = 6'd0;
        wrd_d   = 7'd0;
        cbit_d  = 5'd0;
        tmo_d   = 16'd0;
        stat_d  = 3'b000;
        err_d   = 1'b0;
      end
    endcase
    oe_d   = state_d inside {START, DATA, CRC, END};
    dout_d = oe_d ? dout_d : 1'b1;
    busy_d = (state_d != IDLE);
    tfc_d  = (state_d == DONE);
  end

  always_ff @(posedge sdc_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      crc_q   <= 16'h0000;
      bit_q   <= 6'd0;
      wrd_q   <= 7'd0;
      cbit_q  <= 5'd0;
      tmo_q   <= 16'd0;
      stat_q  <= 3'b000;
      err_q   <= 1'b0;
      dout_q  <= 1'b1;
      oe_q    <= 1'b0;
      strb_q  <= 1'b0;
      busy_q  <= 1'b0;
      tfc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      bit_q   <= bit_d;
      wrd_q   <= wrd_d;
      cbit_q  <= cbit_d;
      tmo_q   <= tmo_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      tfc_q   <= tfc_d;
    end
  end

  assign bus.rd_wrd_strb = strb_q;
  assign bus.d0_out      = dout_q;
  assign bus.d0_oe       = oe_q;
  assign bus.busy        = busy_q;
  assign bus.tfc         = tfc_q;
  assign bus.wr_err      = err_q;
  assign bus.crc_stat    = stat_q;

endmodule

// File: tb/tb_sdc_single_blk_wr_mod.sv
// Bench for sdc_single_blk_wr_mod: FIFO + card model,
// D0 bitstream scoreboard.
module tb_sdc_single_blk_wr_mod;

  logic sdc_clk = 1'b0;
  logic reset   = 1'b1;

  sdc_single_blk_wr_mod_if bus();

  sdc_single_blk_wr_mod dut (
    .sdc_clk (sdc_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sdc_clk = ~sdc_clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [63:0] blk [64];
  bit          exp_q [$];
  int          wr_idx, strb_cnt, tfc_cnt, busy_cnt;
  int          rx_cnt, bit_err, idle_err;
  logic [15:0] rx_crc;
  logic [15:0] mcrc;
  int          lat;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(
      input logic [15:0] c, input bit b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  // FIFO responder and D0 scoreboard, sampled after each edge
  always begin
    @(posedge sdc_clk);
    #1;
    if (bus.busy) busy_cnt++;
    if (bus.tfc) tfc_cnt++;
    if (bus.rd_wrd_strb) begin
      strb_cnt++;
      if (wr_idx < 64) bus.dat_wrd = blk[wr_idx];
      wr_idx++;
    end
    if (bus.d0_oe) begin
      if (exp_q.size() == 0) bit_err++;
      else if (bus.d0_out !== exp_q.pop_front()) bit_err++;
      if (rx_cnt >= 4097 && rx_cnt < 4113)
        rx_crc = {rx_crc[14:0], bus.d0_out};
      rx_cnt++;
    end else if (bus.d0_out !== 1'b1) begin
      idle_err++;
    end
  end

  task automatic load(input int mode, output logic [15:0] crc);
    for (int w = 0; w < 64; w++) begin
      unique case (mode)
        0: blk[w] = 64'h0;
        1: blk[w] = 64'hFFFF_FFFF_FFFF_FFFF;
        2: blk[w] = 64'hC3A5_0000_0000_0100 + 64'(w);
        default: blk[w] = {$urandom, $urandom};
      endcase
    end
    exp_q.delete();
    exp_q.push_back(1'b0);
    crc = 16'h0;
    for (int w = 0; w < 64; w++) begin
      for (int b = 63; b >= 0; b--) begin
        exp_q.push_back(blk[w][b]);
        crc = crc_step(crc, blk[w][b]);
      end
    end
    for (int k = 15; k >= 0; k--) exp_q.push_back(crc[k]);
    exp_q.push_back(1'b1);
    wr_idx = 0; strb_cnt = 0; tfc_cnt = 0; busy_cnt = 0;
    rx_cnt = 0; bit_err = 0; idle_err = 0; rx_crc = 16'h0;
  endtask

  task automatic start(input logic [5:0] idx);
    logic [63:0] w0;
    w0 = blk[0];
    bus.command = {2'b00, idx, 8'h00};
    @(negedge sdc_clk);
    bus.wr_strt = 1'b1;
    @(negedge sdc_clk);
    bus.wr_strt = 1'b0;
    chk("t1_strb", 32'(bus.rd_wrd_strb), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    @(negedge sdc_clk);
    chk("t2_oe", 32'(bus.d0_oe), 0);
    @(negedge sdc_clk);
    chk("t3_start", {30'd0, bus.d0_oe, bus.d0_out}, 32'h2);
    @(negedge sdc_clk);
    chk("t4_bit63", {30'd0, bus.d0_oe, bus.d0_out},
        {30'd0, 1'b1, w0[63]});
  endtask

  task automatic run_card(input bit resp, input int dly,
                          input logic [2:0] st, input int bl,
                          output int l);
    int  n;
    bit  seen;
    logic v;
    n = 0; seen = 0; l = -1;
    while (n < 6000) begin
      @(negedge sdc_clk);
      if (bus.d0_oe) seen = 1;
      else if (seen) break;
      n++;
    end
    if (n >= 6000) begin
      chk("oe_end_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < 400; i++) begin
      if (bus.tfc) begin
        l = i;
        break;
      end
      if (!resp) v = 1'b1;
      else if (i < dly) v = 1'b1;
      else if (i == dly) v = 1'b0;
      else if (i <= dly + 3) v = st[dly + 3 - i];
      else if (i == dly + 4) v = 1'b1;
      else if (i <= dly + 4 + bl) v = 1'b0;
      else v = 1'b1;
      bus.d0_in = v;
      @(negedge sdc_clk);
    end
    bus.d0_in = 1'b1;
  endtask

  task automatic post(input string tg, input logic [2:0] st,
                      input logic err, input int l, input int el,
                      input logic [15:0] ecrc);
    chk({tg, "_lat"}, l, el);
    @(negedge sdc_clk);
    chk({tg, "_busy_off"}, 32'(bus.busy), 0);
    repeat (3) @(negedge sdc_clk);
    chk({tg, "_tfc"}, tfc_cnt, 1);
    chk({tg, "_stat"}, 32'(bus.crc_stat), 32'(st));
    chk({tg, "_err"}, 32'(bus.wr_err), 32'(err));
    chk({tg, "_strb"}, strb_cnt, 64);
    chk({tg, "_bits"}, bit_err, 0);
    chk({tg, "_oe_len"}, rx_cnt, 4114);
    chk({tg, "_left"}, exp_q.size(), 0);
    chk({tg, "_crc"}, 32'(rx_crc), 32'(ecrc));
    chk({tg, "_idle"}, idle_err, 0);
  endtask

  initial begin
    bus.command = 16'h0;
    bus.wr_strt = 1'b0;
    bus.dat_wrd = 64'h0;
    bus.d0_in   = 1'b1;
    load(0, mcrc);
    reset = 1'b1;
    repeat (3) @(negedge sdc_clk);
    chk("rst_oe", 32'(bus.d0_oe), 0);
    chk("rst_out", 32'(bus.d0_out), 1);
    chk("rst_strb", 32'(bus.rd_wrd_strb), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_tfc", 32'(bus.tfc), 0);
    chk("rst_err", 32'(bus.wr_err), 0);
    chk("rst_stat", 32'(bus.crc_stat), 0);
    reset = 1'b0;
    @(negedge sdc_clk);

    load(0, mcrc);
    start(6'h18);
    run_card(1, 4, 3'b010, 10, lat);
    post("zero", 3'b010, 1'b0, lat, 20, 16'h0000);

    load(1, mcrc);
    start(6'h19);
    run_card(1, 4, 3'b010, 10, lat);
    post("ones", 3'b010, 1'b0, lat, 20, 16'h7FA1);

    load(3, mcrc);
    start(6'h18);
    run_card(1, 4, 3'b101, 25, lat);
    post("st101", 3'b101, 1'b1, lat, 35, mcrc);

    load(3, mcrc);
    start(6'h19);
    run_card(0, 0, 3'b000, 0, lat);
    post("nostat", 3'b111, 1'b1, lat, 16, mcrc);

    load(0, mcrc);
    bus.command = 16'h1100;
    bus.wr_strt = 1'b1;
    @(negedge sdc_clk);
    bus.wr_strt = 1'b0;
    repeat (20) @(negedge sdc_clk);
    chk("bad_strb", strb_cnt, 0);
    chk("bad_oe", rx_cnt, 0);
    chk("bad_busy", busy_cnt, 0);
    chk("hold_err", 32'(bus.wr_err), 1);
    chk("hold_stat", 32'(bus.crc_stat), 32'h7);

    load(2, mcrc);
    start(6'h18);
    for (int n = 0; n < 2000 && rx_cnt < 1001; n++)
      @(negedge sdc_clk);
    chk("mid_reach", 32'(rx_cnt >= 1001), 1);
    reset = 1'b1;
    @(negedge sdc_clk);
    chk("mid_oe", 32'(bus.d0_oe), 0);
    chk("mid_out", 32'(bus.d0_out), 1);
    chk("mid_busy", 32'(bus.busy), 0);
    @(negedge sdc_clk);
    reset = 1'b0;
    repeat (20) @(negedge sdc_clk);
    chk("mid_no_tfc", tfc_cnt, 0);
    chk("mid_err_clr", 32'(bus.wr_err), 0);

    load(2, mcrc);
    start(6'h18);
    run_card(1, 2, 3'b010, 5, lat);
    post("after_rst", 3'b010, 1'b0, lat, 13, mcrc);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
